d_cache_fm_responder: RTL and testbench

Far-memory (FM) responder model and controller that sits on the cache-to-FM interface of the d_cache memory subsystem.
- Accepts fill-read and eviction-write requests issued by the d_cache.
- Buffers requests in an in-order request FIFO.
- Services them against a line-wide backing store.
- Returns each fill read to the d_cache as a single-cycle fm2cache_rd_rsp pulse, carrying the originating TQ id, after a fixed latency.

---
 rtl/d_cache_fm_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_d_cache_fm_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_fm_responder.sv
`default_nettype none
// ============================================================================
// Module   : d_cache_fm_responder
// Purpose  : Far-memory responder on the d_cache -> FM interface. Accepts
//            FILL_RD / EVICT_WR requests into an in-order request FIFO and
//            services them against a line-wide backing store. Each fill read
//            returns as a single-cycle response pulse after a fixed latency.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            req_valid/req_ready  - request handshake
//            req_opcode           - 0 = FILL_RD, 1 = EVICT_WR
//            req_tq_id            - owning transaction-queue id
//            req_cl_address       - cache-line address (address[31:4])
//            req_cl_data          - line data, used by EVICT_WR only
//            rsp_valid            - single-cycle read response pulse
//            rsp_tq_id            - echoed tq id
//            rsp_cl_address       - echoed full line address
//            rsp_data             - line data read from the backing store
// Revision : 1.0 - initial release
// ============================================================================
module d_cache_fm_responder #(
    parameter int FM_LINES       = 256,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int RD_LATENCY     = 8,
    parameter int TQ_ID_W        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_opcode,
    input  logic [TQ_ID_W-1:0] req_tq_id,
    input  logic [27:0]        req_cl_address,
    input  logic [127:0]       req_cl_data,
    output logic               rsp_valid,
    output logic [TQ_ID_W-1:0] rsp_tq_id,
    output logic [27:0]        rsp_cl_address,
    output logic [127:0]       rsp_data
);

    localparam int c_IDX_W = $clog2(FM_LINES);
    localparam int c_PTR_W = $clog2(REQ_FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(RD_LATENCY);

    localparam logic [c_PTR_W:0]   c_DEPTH     = (c_PTR_W+1)'(REQ_FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(RD_LATENCY - 2);

    localparam logic c_OP_FILL_RD  = 1'b0;
    localparam logic c_OP_EVICT_WR = 1'b1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RD_RSP  = 2'd2;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (RD_LATENCY < 2) begin : g_bad_latency
            $error("d_cache_fm_responder: RD_LATENCY must be at least 2");
        end
        if ((FM_LINES < 2) || ((FM_LINES & (FM_LINES - 1)) != 0)) begin : g_bad_lines
            $error("d_cache_fm_responder: FM_LINES must be a power of 2");
        end
        if ((REQ_FIFO_DEPTH < 2) || ((REQ_FIFO_DEPTH & (REQ_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("d_cache_fm_responder: REQ_FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic               r_alive;      // low until the first edge after reset release
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_count_nxt;

    logic               r_fifo_op   [REQ_FIFO_DEPTH];
    logic [TQ_ID_W-1:0] r_fifo_tq   [REQ_FIFO_DEPTH];
    logic [27:0]        r_fifo_addr [REQ_FIFO_DEPTH];
    logic [127:0]       r_fifo_data [REQ_FIFO_DEPTH];

    // Backing store: zero at time 0, never touched by reset.
    logic [127:0]       r_store [FM_LINES] = '{default: '0};

    logic               w_head_op;
    logic [TQ_ID_W-1:0] w_head_tq;
    logic [27:0]        w_head_addr;
    logic [127:0]       w_head_data;
    logic               w_fifo_empty;

    logic               w_push;
    logic               w_pop;
    logic               w_store_we;
    logic               w_rd_start;
    logic               w_rsp_load;
    logic               w_rsp_valid;

    logic [TQ_ID_W-1:0] r_rd_tq;
    logic [27:0]        r_rd_addr;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic [TQ_ID_W-1:0] r_rsp_tq;
    logic [27:0]        r_rsp_addr;
    logic [127:0]       r_rsp_data;

    // ------------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------------
    assign w_fifo_empty = (r_count == '0);
    assign w_head_op    = r_fifo_op[r_rd_ptr];
    assign w_head_tq    = r_fifo_tq[r_rd_ptr];
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];

    // Ready depends only on the registered count, so a pop in this cycle
    // cannot make room for a push in the same cycle.
    assign req_ready = r_alive && (r_count < c_DEPTH);
    assign w_push    = req_valid && req_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_alive <= 1'b1;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= req_opcode;
            r_fifo_tq[r_wr_ptr]   <= req_tq_id;
            r_fifo_addr[r_wr_ptr] <= req_cl_address;
            r_fifo_data[r_wr_ptr] <= req_cl_data;
        end
    end

    // ------------------------------------------------------------------------
    // Backing store write port (upper address bits alias onto the index)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            r_store[w_head_addr[c_IDX_W-1:0]] <= w_head_data;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // The response cycle also dispatches the next head, so consecutive reads
    // are spaced exactly RD_LATENCY cycles apart.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RD_RSP: begin
                if (w_fifo_empty || (w_head_op == c_OP_EVICT_WR)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_RD_RSP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_rsp_valid = 1'b0;
        w_pop       = 1'b0;
        w_store_we  = 1'b0;
        w_rd_start  = 1'b0;
        w_rsp_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop      = !w_fifo_empty;
                w_store_we = w_pop && (w_head_op == c_OP_EVICT_WR);
                w_rd_start = w_pop && (w_head_op == c_OP_FILL_RD);
            end
            S_RD_WAIT: begin
                w_rsp_load = (r_wait_cnt == '0);
            end
            S_RD_RSP: begin
                w_rsp_valid = 1'b1;
                w_pop       = !w_fifo_empty;
                w_store_we  = w_pop && (w_head_op == c_OP_EVICT_WR);
                w_rd_start  = w_pop && (w_head_op == c_OP_FILL_RD);
            end
            default: begin
                w_rsp_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read datapath: latched request, wait counter and held response fields.
    // Response data is sampled from the store on entry to the response
    // cycle; every earlier-accepted write has already been committed then.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_tq    <= '0;
            r_rd_addr  <= '0;
            r_wait_cnt <= '0;
            r_rsp_tq   <= '0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_rd_start) begin
                r_rd_tq    <= w_head_tq;
                r_rd_addr  <= w_head_addr;
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == S_RD_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_rsp_load) begin
                r_rsp_tq   <= r_rd_tq;
                r_rsp_addr <= r_rd_addr;
                r_rsp_data <= r_store[r_rd_addr[c_IDX_W-1:0]];
            end
        end
    end

    assign rsp_valid      = w_rsp_valid;
    assign rsp_tq_id      = r_rsp_tq;
    assign rsp_cl_address = r_rsp_addr;
    assign rsp_data       = r_rsp_data;

    // ------------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------------
    a_rsp_single_cycle: assert property (
        @(posedge clk) disable iff (!rst_n) rsp_valid |=> !rsp_valid
    );

    a_fifo_bound: assert property (
        @(posedge clk) disable iff (!rst_n) r_count <= c_DEPTH
    );

endmodule
`default_nettype wire

// File: tb/tb_d_cache_fm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_cache_fm_responder
// Purpose  : Self-checking bench for d_cache_fm_responder. A reference model
//            schedules every accepted request (service start, response cycle)
//            from the latency/ordering rules and holds a line-array image of
//            the backing store; DUT outputs are compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_cache_fm_responder;

    localparam int FM_LINES = 256;
    localparam int DEPTH    = 4;
    localparam int LAT      = 8;
    localparam int TQW      = 3;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_opcode = 1'b0;
    logic [TQW-1:0] req_tq_id = '0;
    logic [27:0]    req_cl_address = '0;
    logic [127:0]   req_cl_data = '0;
    logic           rsp_valid;
    logic [TQW-1:0] rsp_tq_id;
    logic [27:0]    rsp_cl_address;
    logic [127:0]   rsp_data;

    d_cache_fm_responder #(
        .FM_LINES       (FM_LINES),
        .REQ_FIFO_DEPTH (DEPTH),
        .RD_LATENCY     (LAT),
        .TQ_ID_W        (TQW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_tq_id      (req_tq_id),
        .req_cl_address (req_cl_address),
        .req_cl_data    (req_cl_data),
        .rsp_valid      (rsp_valid),
        .rsp_tq_id      (rsp_tq_id),
        .rsp_cl_address (rsp_cl_address),
        .rsp_data       (rsp_data)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of the cycle just begun.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        bit             wr;
        logic [TQW-1:0] tq;
        logic [27:0]    addr;
        logic [127:0]   data;
        int             pop;   // edge at which the responder takes it
        int             due;   // cycle of the response pulse (reads)
    } op_t;

    op_t            ops[$];
    logic [127:0]   mem [FM_LINES];
    int             t_free     = 0;
    int             ready_from = 1 << 30;
    bit             in_reset   = 1'b1;
    bit             exp_rdy    = 1'b0;
    logic [TQW-1:0] last_tq    = '0;
    logic [27:0]    last_addr  = '0;
    logic [127:0]   last_data  = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [27:0] a);
        return int'(a) % FM_LINES;
    endfunction

    // Compare every DUT output for the current cycle against the model.
    task automatic observe();
        int c = cyc;
        int occ = 0;
        bit exp_v = 1'b0;
        while (ops.size() > 0) begin
            if (ops[0].wr && ops[0].pop <= c) begin
                mem[idx_of(ops[0].addr)] = ops[0].data;
                void'(ops.pop_front());
            end else if (!ops[0].wr && ops[0].due < c) begin
                void'(ops.pop_front());
            end else begin
                break;
            end
        end
        if (ops.size() > 0 && !ops[0].wr && ops[0].due == c) begin
            exp_v     = 1'b1;
            last_tq   = ops[0].tq;
            last_addr = ops[0].addr;
            last_data = mem[idx_of(ops[0].addr)];
        end
        foreach (ops[i]) if (ops[i].pop > c) occ++;
        exp_rdy = !in_reset && (c >= ready_from) && (occ < DEPTH);
        check_eq("rsp_valid",      128'(rsp_valid),      128'(exp_v));
        check_eq("rsp_tq_id",      128'(rsp_tq_id),      128'(last_tq));
        check_eq("rsp_cl_address", 128'(rsp_cl_address), 128'(last_addr));
        check_eq("rsp_data",       rsp_data,             last_data);
        check_eq("req_ready",      128'(req_ready),      128'(exp_rdy));
    endtask

    // Record a request that the model says is accepted at the next edge.
    task automatic accept(input bit wr, input logic [TQW-1:0] tq,
                          input logic [27:0] addr, input logic [127:0] data);
        op_t o;
        int  a = cyc + 1;
        int  start = (a + 1 > t_free) ? a + 1 : t_free;
        o.wr = wr; o.tq = tq; o.addr = addr; o.data = data; o.pop = start;
        if (wr) begin
            o.due  = -1;
            t_free = start + 1;
        end else begin
            o.due  = start + LAT - 1;
            t_free = start + LAT;
        end
        ops.push_back(o);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send(input bit wr, input logic [TQW-1:0] tq,
                        input logic [27:0] addr, input logic [127:0] data);
        int waited = 0;
        forever begin
            @(negedge clk);
            observe();
            req_valid      = 1'b1;
            req_opcode     = wr;
            req_tq_id      = tq;
            req_cl_address = addr;
            req_cl_data    = data;
            if (exp_rdy) begin
                accept(wr, tq, addr, data);
                break;
            end
            waited++;
            if (waited > 200) begin
                check_eq("req_ready_timeout", 128'(0), 128'(1));
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            observe();
            req_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        observe();
        rst_n      = 1'b0;
        in_reset   = 1'b1;
        req_valid  = 1'b0;
        ops.delete();
        t_free     = 0;
        ready_from = 1 << 30;
        last_tq    = '0;
        last_addr  = '0;
        last_data  = '0;
        repeat (n - 1) begin
            @(negedge clk);
            observe();
        end
        @(negedge clk);
        observe();
        rst_n      = 1'b1;
        in_reset   = 1'b0;
        ready_from = cyc + 1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        foreach (mem[i]) mem[i] = '0;
        rst_n = 1'b0;

        // Power-on reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            observe();
        end
        rst_n      = 1'b1;
        in_reset   = 1'b0;
        ready_from = cyc + 1;
        idle(2);

        // Write then read back with tq 3
        send(1'b1, 3'd0, 28'h0000005, 128'h11223344_55667788_99AABBCC_DDEEFF00);
        idle(2);
        send(1'b0, 3'd3, 28'h0000005, rnd128());
        idle(LAT + 2);

        // Six back-to-back reads: FIFO fills, responses in order
        for (int i = 0; i < 6; i++) send(1'b0, TQW'(i), 28'(i), rnd128());
        idle(LAT * 7);

        // Aliasing: upper address bits ignored for the index
        send(1'b1, 3'd0, 28'h0000105, {16{8'hA5}});
        send(1'b0, 3'd1, 28'h0000005, rnd128());
        idle(LAT + 2);

        // Reset during RD_WAIT discards the read; store contents survive
        send(1'b0, 3'd4, 28'h0000005, rnd128());
        idle(3);
        pulse_reset(1);
        idle(LAT + 2);
        send(1'b0, 3'd5, 28'h0000105, rnd128());
        idle(LAT + 2);

        // Read-before-write returns old data, later read sees new data
        send(1'b0, 3'd2, 28'h0000007, rnd128());
        send(1'b1, 3'd0, 28'h0000007, {128{1'b1}});
        send(1'b0, 3'd6, 28'h0000007, rnd128());
        idle(2 * LAT + 4);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 250; i++) begin
            int          r = int'($urandom_range(0, 99));
            logic [27:0] a = 28'($urandom);
            a[7:0] = 8'($urandom_range(0, 15));
            if (r < 3) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else if (r < 20) begin
                idle(int'($urandom_range(1, 6)));
            end else begin
                send(1'($urandom_range(0, 1)), TQW'($urandom), a, rnd128());
            end
        end
        idle(LAT * (DEPTH + 2) + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
